register_tree_pq: RTL

//  Parametrised successor register-tree priority queue: a binary tree of registers kept heap-ordered
//  by alternating even/odd-level compare-swap passes, one comparator per internal node.

---
 rtl/register_tree_pq_if.sv | 28 ++
 rtl/register_tree_pq.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/register_tree_pq_if.sv
// rtl/register_tree_pq_if.sv - push/pop/clear request and queue status bundle for register_tree_pq
interface register_tree_pq_if #(
    parameter int DATA_WIDTH = 16,
    parameter int COUNT_W    = 3
);
    logic                  i_push;
    logic                  i_pop;
    logic                  i_clear;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_ready;
    logic                  o_valid;
    logic [DATA_WIDTH-1:0] o_data;
    logic [COUNT_W-1:0]    o_count;
    logic                  o_full;
    logic                  o_empty;
    logic                  o_overflow;
    logic                  o_underflow;

    modport master (
        output i_push, i_pop, i_clear, i_data,
        input  o_ready, o_valid, o_data, o_count, o_full, o_empty, o_overflow, o_underflow
    );

    modport slave (
        input  i_push, i_pop, i_clear, i_data,
        output o_ready, o_valid, o_data, o_count, o_full, o_empty, o_overflow, o_underflow
    );
endinterface

// File: rtl/register_tree_pq.sv
// rtl/register_tree_pq.sv - heap-ordered register-tree priority queue with even/odd compare-swap passes
module register_tree_pq #(
    parameter int QUEUE_SIZE = 7,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_FIRST  = 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    register_tree_pq_if.slave bus
);
    localparam int D  = $clog2(QUEUE_SIZE + 1);
    localparam int N  = (1 << D) - 1;
    localparam int CW = $clog2(QUEUE_SIZE + 1);
    localparam int SW = $clog2(D + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int EW = DATA_WIDTH + 1;
    localparam logic [CW-1:0] QS_C = CW'(QUEUE_SIZE);
    localparam logic [SW-1:0] D_C  = SW'(D);

    typedef enum logic {SORT_EVEN, SORT_ODD} state_e;

    state_e                 state_q;
    logic [N-1:0][EW-1:0]   node_q;
    logic [N-1:0][EW-1:0]   pass_d;
    logic [CW-1:0]          count_q;
    logic [SW-1:0]          settle_q;
    logic                   overflow_q;
    logic                   underflow_q;
    logic [N-1:0]           swap_l;
    logic [N-1:0]           swap_r;
    logic [IW-1:0]          free_idx;

    logic ready, do_replace, do_push, do_pop, drop_push, drop_pop, accept;

    // Node entry is {valid, key}; an invalid entry ranks below every valid one.
    function automatic logic better(input logic [EW-1:0] a, input logic [EW-1:0] b);
        logic gt, lt;
        gt = a[DATA_WIDTH-1:0] > b[DATA_WIDTH-1:0];
        lt = a[DATA_WIDTH-1:0] < b[DATA_WIDTH-1:0];
        if (!a[EW-1])      better = 1'b0;
        else if (!b[EW-1]) better = 1'b1;
        else               better = (MAX_FIRST != 0) ? gt : lt;
    endfunction

    for (genvar j = 0; j < N; j++) begin : g_cmp
        localparam int LVL = $clog2(j + 2) - 1;
        if (2 * j + 2 < N) begin : g_int
            logic [EW-1:0] lc, rc, bc;
            logic          pick_r, active, do_swap;
            assign lc      = node_q[2*j+1];
            assign rc      = node_q[2*j+2];
            assign pick_r  = !lc[EW-1] || better(rc, lc);
            assign bc      = pick_r ? rc : lc;
            assign active  = (state_q == SORT_EVEN) == ((LVL % 2) == 0);
            assign do_swap = active && better(bc, node_q[j]);
            assign swap_l[j] = do_swap && !pick_r;
            assign swap_r[j] = do_swap &&  pick_r;
        end else begin : g_leaf
            assign swap_l[j] = 1'b0;
            assign swap_r[j] = 1'b0;
        end
    end

    // Adjacent levels never run in the same pass, so a node is updated either as parent or as child.
    for (genvar j = 0; j < N; j++) begin : g_pass
        logic [EW-1:0] as_parent;
        if (2 * j + 2 < N) begin : g_par
            assign as_parent = swap_l[j] ? node_q[2*j+1] :
                               swap_r[j] ? node_q[2*j+2] : node_q[j];
        end else begin : g_nopar
            assign as_parent = node_q[j];
        end
        if (j == 0) begin : g_root
            assign pass_d[j] = as_parent;
        end else if ((j % 2) == 1) begin : g_left
            assign pass_d[j] = swap_l[(j-1)/2] ? node_q[(j-1)/2] : as_parent;
        end else begin : g_right
            assign pass_d[j] = swap_r[(j-1)/2] ? node_q[(j-1)/2] : as_parent;
        end
    end

    always_comb begin
        free_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (!node_q[k][EW-1]) free_idx = IW'(k);
        end
    end

    assign ready      = (settle_q == '0);
    assign do_replace = ready && bus.i_push && bus.i_pop && (count_q != '0);
    assign do_push    = ready && bus.i_push && (!bus.i_pop || (count_q == '0)) && (count_q != QS_C);
    assign drop_push  = ready && bus.i_push && !bus.i_pop && (count_q == QS_C);
    assign do_pop     = ready && bus.i_pop && !bus.i_push && (count_q != '0);
    assign drop_pop   = ready && bus.i_pop && !bus.i_push && (count_q == '0);
    assign accept     = do_replace || do_push || do_pop;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            node_q      <= '0;
            count_q     <= '0;
            settle_q    <= '0;
            state_q     <= SORT_EVEN;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.i_clear) begin
            node_q      <= '0;
            count_q     <= '0;
            settle_q    <= '0;
            state_q     <= SORT_EVEN;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= drop_push;
            underflow_q <= drop_pop;
            if (accept) begin
                state_q  <= SORT_EVEN;
                settle_q <= D_C;
                if (do_replace) begin
                    node_q[0] <= {1'b1, bus.i_data};
                end else if (do_push) begin
                    node_q[free_idx] <= {1'b1, bus.i_data};
                    count_q          <= count_q + CW'(1);
                end else begin
                    node_q[0][EW-1] <= 1'b0;
                    count_q         <= count_q - CW'(1);
                end
            end else begin
                node_q  <= pass_d;
                state_q <= (state_q == SORT_EVEN) ? SORT_ODD : SORT_EVEN;
                if (settle_q != '0) settle_q <= settle_q - SW'(1);
            end
        end
    end

    assign bus.o_ready     = ready;
    assign bus.o_valid     = ready && node_q[0][EW-1];
    assign bus.o_data      = (ready && node_q[0][EW-1]) ? node_q[0][DATA_WIDTH-1:0] : '0;
    assign bus.o_count     = count_q;
    assign bus.o_full      = (count_q == QS_C);
    assign bus.o_empty     = (count_q == '0);
    assign bus.o_overflow  = overflow_q;
    assign bus.o_underflow = underflow_q;
endmodule
